// File: rtl/axis_width_packer.sv
// axis_width_packer: packs N narrow AXI-Stream beats into one wide word with per-lane tkeep.
// Define AXIS_WIDTH_PACKER_TLAST_EN to let s_axis_tlast flush partial groups.
module axis_width_packer #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [15:0]                         cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [S_AXIS_TDATA_WIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]                    m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast
);
  localparam int S = S_AXIS_TDATA_WIDTH;
  localparam int M = S * RATIO;
  localparam int C = $clog2(RATIO);
  localparam logic [C-1:0] MAX_IDX = C'(RATIO - 1);
  logic [C-1:0] cnt, last_idx, cfg_idx, cur_last;
  logic [M-1:0] acc, word;
  logic [RATIO-1:0] keep;
  logic accept, flush, done;
`ifdef AXIS_WIDTH_PACKER_TLAST_EN
  assign flush = s_axis_tlast;
`else
  assign flush = s_axis_tlast & 1'b0;
`endif
  assign s_axis_tready = aresetn & (~m_axis_tvalid | m_axis_tready);
  assign accept = s_axis_tvalid & s_axis_tready;
  assign cfg_idx = (cfg_data > 16'(RATIO - 1)) ? MAX_IDX : cfg_data[C-1:0];
  // the first beat of a group uses live cfg; later beats use the latched group size
  assign cur_last = (cnt == '0) ? cfg_idx : last_idx;
  assign done = accept & ((cnt == cur_last) | flush);
  assign word = acc | (M'(s_axis_tdata) << (32'(cnt) * S));
  assign keep = {RATIO{1'b1}} >> (MAX_IDX - cnt);
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt           <= '0;
      last_idx      <= '0;
      acc           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (accept && cnt == '0) last_idx <= cfg_idx;
      if (done) begin
        cnt           <= '0;
        acc           <= '0;
        m_axis_tdata  <= word;
        m_axis_tkeep  <= keep;
        m_axis_tlast  <= flush;
        m_axis_tvalid <= 1'b1;
      end else begin
        if (accept) begin
          cnt <= cnt + 1'b1;
          acc <= word;
        end
        if (m_axis_tready) m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule
